// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus arbiter: CDB packet layout and
// functional-unit index assignments.
package cdb_arbiter_pkg;

   localparam int unsigned NUM_FU    = 4;
   localparam int unsigned FU_ALU    = 0;
   localparam int unsigned FU_MUL    = 1;
   localparam int unsigned FU_MEM    = 2;
   localparam int unsigned FU_BRANCH = 3;

   typedef struct packed {
      logic        valid;
      logic [5:0]  preg;
      logic [31:0] data;
      logic [4:0]  rob_id;
   } cdb_t;

   // Pointer width that stays legal for a single requester.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin arbiter: searches from i_ptr upward (mod NUM_REQ) and grants
// the first active request as a one-hot vector plus its index.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0]   o_gnt_idx,
   output logic               o_gnt_vld
);

   always_comb begin
      int unsigned w_idx;
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_gnt_vld = 1'b0;
      w_idx     = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         w_idx = (32'(i_ptr) + off) % NUM_REQ;
         if (!o_gnt_vld && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            o_gnt_idx    = PTR_W'(w_idx);
            o_gnt_vld    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant to functional units, one-cycle-delayed grant
// tracking, registered broadcast of the granted unit's packet, sticky collision flag.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_FU
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [NUM_REQ-1:0]       fu_busy,
   input  cdb_t [NUM_REQ-1:0]       fu_cdb,
   output logic [NUM_REQ-1:0]       cdb_grant,
   output cdb_t                     cdb_out,
   output logic                     collision_err
);

   localparam int unsigned PTR_W = ptr_width(NUM_REQ);

   logic [PTR_W-1:0]   r_rr_ptr;
   logic [NUM_REQ-1:0] r_gnt_q;
   cdb_t               r_cdb_out;
   logic               r_collision;

   logic [NUM_REQ-1:0] w_req;
   logic [NUM_REQ-1:0] w_gnt;
   logic [PTR_W-1:0]   w_gnt_idx;
   logic               w_gnt_vld;
   logic [PTR_W-1:0]   w_ptr_next;
   logic [NUM_REQ-1:0] w_valid;
   logic [PTR_W-1:0]   w_sel_idx;
   cdb_t               w_sel;
   logic               w_sel_vld;
   logic               w_multi;
   logic               w_stray;

   // Masking requests covers both the reset and flush "no grant" cases.
   assign w_req = (rst || flush) ? '0 : fu_busy;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .i_req     (w_req),
      .i_ptr     (r_rr_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_gnt_vld (w_gnt_vld)
   );

   assign w_ptr_next = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

   always_comb begin
      w_valid   = '0;
      w_sel_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_valid[i] = fu_cdb[i].valid;
         if (r_gnt_q[i]) w_sel_idx = PTR_W'(i);
      end
   end

   assign w_sel     = fu_cdb[w_sel_idx];
   assign w_sel_vld = (|r_gnt_q) && w_sel.valid;
   assign w_multi   = |(w_valid & (w_valid - NUM_REQ'(1)));
   assign w_stray   = |(w_valid & ~r_gnt_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_gnt_q     <= '0;
         r_cdb_out   <= '0;
         r_collision <= 1'b0;
      end else begin
         if (w_gnt_vld) r_rr_ptr <= w_ptr_next;
         r_gnt_q <= w_gnt;
         if (w_stray || w_multi) r_collision <= 1'b1;
         // Payload fields hold when nothing is broadcast; only valid drops.
         if (!flush && w_sel_vld) r_cdb_out <= w_sel;
         else                     r_cdb_out.valid <= 1'b0;
      end
   end

   assign cdb_grant     = w_gnt;
   assign cdb_out       = r_cdb_out;
   assign collision_err = r_collision;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [3:0] fu_busy;
   cdb_t [3:0] fu_cdb;
   logic [3:0] cdb_grant;
   cdb_t       cdb_out;
   logic       collision_err;

   int   tests = 0;
   int   fails = 0;

   int   m_ptr;
   int   m_gq;
   cdb_t m_out;
   bit   m_err;
   int   last_g;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .fu_busy       (fu_busy),
      .fu_cdb        (fu_cdb),
      .cdb_grant     (cdb_grant),
      .cdb_out       (cdb_out),
      .collision_err (collision_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant();
      if (rst || flush) return -1;
      for (int off = 0; off < 4; off++) begin
         if (fu_busy[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] onehot(input int g);
      logic [3:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   function automatic cdb_t rand_pkt();
      cdb_t p;
      p.valid  = 1'b1;
      p.preg   = 6'($urandom);
      p.data   = $urandom;
      p.rob_id = 5'($urandom);
      return p;
   endfunction

   // One clock: check at negedge, then advance the model across the posedge.
   task automatic cycle();
      int g;
      int nv;
      bit stray;
      @(negedge clk);
      g = model_grant();
      chk("grant", 64'(cdb_grant), 64'(onehot(g)));
      chk("cdb_out", 64'(cdb_out), 64'(m_out));
      chk("collision_err", 64'(collision_err), 64'(m_err));
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_gq = -1; m_out = '0; m_err = 0;
      end else begin
         nv = 0; stray = 0;
         for (int i = 0; i < 4; i++) begin
            if (fu_cdb[i].valid) begin
               nv++;
               if (i != m_gq) stray = 1;
            end
         end
         if (nv > 1 || stray) m_err = 1;
         if (!flush && m_gq >= 0 && fu_cdb[m_gq].valid) m_out = fu_cdb[m_gq];
         else m_out.valid = 1'b0;
         if (g >= 0) m_ptr = (g + 1) % 4;
         m_gq = g;
      end
      last_g = g;
      #1;
   endtask

   // Well-behaved FUs: the unit granted last cycle drives its packet now.
   task automatic drive_fu(input bit drop);
      fu_cdb = '0;
      if (last_g >= 0 && !drop) fu_cdb[last_g] = rand_pkt();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cdb_t pkt;
      rst = 1'b1; flush = 1'b0; fu_busy = 4'b1111; fu_cdb = '0; last_g = -1;
      repeat (2) @(posedge clk);
      #1;
      m_ptr = 0; m_gq = -1; m_out = '0; m_err = 0;
      chk("rst_grant", 64'(cdb_grant), 64'(4'b0000));
      chk("rst_out", 64'(cdb_out), 64'(0));
      chk("rst_err", 64'(collision_err), 64'(0));
      rst = 1'b0;

      // Single grant to branch unit, packet broadcast two cycles later.
      fu_busy = 4'b1000; fu_cdb = '0; #1;
      chk("req027_grant", 64'(cdb_grant), 64'(4'b1000));
      cycle();
      fu_busy = 4'b0000;
      pkt = '{valid: 1'b1, preg: 6'd5, data: 32'h100, rob_id: 5'd2};
      fu_cdb = '0; fu_cdb[3] = pkt;
      cycle();
      chk("req027_out", 64'(cdb_out), 64'(pkt));
      fu_cdb = '0;
      cycle();

      // All busy from pointer 0: grants rotate 0,1,2,3.
      fu_busy = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         drive_fu(0); #1;
         chk("req028_rot", 64'(cdb_grant), 64'(4'b0001 << k));
         cycle();
      end

      // Move pointer to 2, then 0011 must wrap to index 0.
      fu_busy = 4'b0010; drive_fu(0); cycle();
      fu_busy = 4'b0011; drive_fu(0); #1;
      chk("req029_wrap", 64'(cdb_grant), 64'(4'b0001));
      cycle();
      fu_busy = 4'b1111; drive_fu(0); #1;
      chk("req029_ptr1", 64'(cdb_grant), 64'(4'b0010));
      fu_busy = 4'b0000; cycle();
      drive_fu(0); cycle();

      // Grant idx1, flush the next cycle while its packet arrives.
      fu_busy = 4'b0010; fu_cdb = '0; cycle();
      flush = 1'b1; fu_busy = 4'b1111; drive_fu(0); #1;
      chk("req030_flush_grant", 64'(cdb_grant), 64'(4'b0000));
      cycle();
      flush = 1'b0; fu_busy = 4'b0000; fu_cdb = '0;
      chk("req030_valid", 64'(cdb_out.valid), 64'(0));
      cycle();

      // Granted unit fails to drive: no broadcast, no error.
      fu_busy = 4'b0100; cycle();
      fu_busy = 4'b0000; drive_fu(1); cycle();
      fu_cdb = '0;
      chk("req018_valid", 64'(cdb_out.valid), 64'(0));
      chk("req018_err", 64'(collision_err), 64'(0));
      cycle();

      // Reset right after a grant discards the in-flight packet.
      fu_busy = 4'b0100; cycle();
      rst = 1'b1; fu_busy = 4'b0000; drive_fu(0); cycle();
      rst = 1'b0; fu_cdb = '0; fu_busy = 4'b1111; #1;
      chk("req032_valid", 64'(cdb_out.valid), 64'(0));
      chk("req032_ptr0", 64'(cdb_grant), 64'(4'b0001));
      cycle();
      fu_busy = 4'b0000; drive_fu(0); cycle();
      fu_cdb = '0; cycle();

      // Random protocol-compliant traffic with flushes, drops and resets.
      for (int n = 0; n < 400; n++) begin
         fu_busy = 4'($urandom);
         flush   = ($urandom_range(0, 11) == 0);
         rst     = ($urandom_range(0, 49) == 0);
         drive_fu($urandom_range(0, 7) == 0);
         cycle();
      end
      rst = 1'b0; flush = 1'b0; fu_busy = 4'b0000; drive_fu(0); cycle();
      fu_cdb = '0; cycle();

      // Unsolicited valid sets the sticky error.
      fu_cdb = '0; fu_cdb[0] = rand_pkt(); cycle();
      fu_cdb = '0;
      chk("req031_set", 64'(collision_err), 64'(1));
      repeat (3) cycle();
      chk("req031_held", 64'(collision_err), 64'(1));
      rst = 1'b1; cycle();
      rst = 1'b0;
      chk("req031_clear", 64'(collision_err), 64'(0));

      // Two simultaneous valids also set the error.
      fu_cdb[1] = rand_pkt(); fu_cdb[2] = rand_pkt(); cycle();
      fu_cdb = '0; cycle();
      chk("multi_valid_err", 64'(collision_err), 64'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL give the number of functional-unit requesters (index 0 alu, 1 mul, 2 mem, 3 branch).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 flush  input  1  SHALL be the pipeline squash: suppresses grants and broadcast.
REQ-005 fu_busy  input  NUM_REQ  SHALL carry each FU's buffered-result-pending flag (request).
REQ-006 fu_cdb  input  NUM_REQ x cdb_t  SHALL carry each FU's registered CDB packet {valid, preg[5:0], data[31:0], rob_id[4:0]}.
REQ-007 cdb_grant  output  NUM_REQ  SHALL be the one-hot-or-zero grant to each FU.
REQ-008 cdb_out  output  cdb_t  SHALL be the registered broadcast to reservation stations, register file and ROB.
REQ-009 collision_err  output  1  SHALL be a sticky error flag.

Function
REQ-010 cdb_grant SHALL be combinational from fu_busy, rr_ptr and flush, and SHALL have at most one bit set.
REQ-011 Arbitration SHALL be round-robin: search indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ; grant the first with fu_busy=1.
REQ-012 rr_ptr SHALL be clog2(NUM_REQ) bits, and SHALL update to (granted index + 1) mod NUM_REQ on a granting cycle and hold otherwise.
REQ-013 When flush=1, cdb_grant SHALL be all zero and rr_ptr SHALL hold.
REQ-014 An FU granted at cycle t drives fu_cdb.valid at t+1; the arbiter SHALL register the packet from the single valid fu_cdb into cdb_out at the t+1 edge, so cdb_out.valid is high in cycle t+2.
REQ-015 Latency fu_busy→cdb_out.valid SHALL be 2 cycles; throughput SHALL be one broadcast per cycle.
REQ-016 The arbiter SHALL track each grant in a one-cycle-delayed grant register (gnt_q) and SHALL select the fu_cdb index from gnt_q.
REQ-017 If any fu_cdb.valid is high without the matching gnt_q bit, or more than one fu_cdb.valid is high, collision_err SHALL set and stay set until rst; the broadcast SHALL still use the gnt_q index.
REQ-018 gnt_q set while fu_cdb.valid of that index is 0 SHALL produce cdb_out.valid=0 next cycle, with no error.
REQ-019 flush=1 SHALL clear gnt_q and force cdb_out.valid to 0 at the next edge; packets arriving that cycle SHALL be dropped.
REQ-020 A requester re-asserting fu_busy the cycle after its grant (back-to-back result) SHALL be treated as a new request, subject to round-robin order.
REQ-021 cdb_out.preg/data/rob_id SHALL hold their last values when cdb_out.valid=0.

Reset
REQ-022 On rst, rr_ptr SHALL be 0, gnt_q 0, cdb_out all fields 0, collision_err 0.
REQ-023 During rst, cdb_grant SHALL be all zero.
REQ-024 rst mid-transfer SHALL discard in-flight grant and packet; no broadcast SHALL occur in the first cycle after rst deasserts.

Structure
REQ-025 cdb_t, NUM_FU and FU index constants SHALL live in the shared package types.
REQ-026 One sub-module, rr_arbiter (request vector + pointer → one-hot grant), SHALL be instantiated.

Verification
REQ-027 rst, then fu_busy=4'b1000 at t → cdb_grant=4'b1000 at t; fu_cdb[3]={1,6'd5,32'h100,5'd2} at t+1 → cdb_out identical at t+2; rr_ptr=0.
REQ-028 fu_busy=4'b1111 held 4 cycles from rr_ptr=0 → grants 0001, 0010, 0100, 1000 in order.
REQ-029 rr_ptr=2, fu_busy=4'b0011 → grant 4'b0001, rr_ptr becomes 1.
REQ-030 Grant to idx1 at t, flush=1 at t+1 → cdb_out.valid=0 at t+2; cdb_grant=0 during flush cycle.
REQ-031 fu_cdb[0].valid=1 with no prior grant → collision_err=1 from next cycle, held until rst.
REQ-032 rst asserted the cycle after a grant → cdb_out.valid=0, rr_ptr=0 after rst.
